// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory controller
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    // WAIT_CYCLES is limited to 0..15, so a 4-bit down-counter is enough
    localparam int CNT_W = 4;

    function automatic int lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - request/response channel bundle between load/store stage and dmem_ctrl
interface dmem_if
    import dmem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) ();

    logic                        req_valid;
    logic                        req_ready;
    logic                        req_we;
    logic [ADDR_W-1:0]           req_addr;
    logic [DATA_W-1:0]           req_wdata;
    logic [lanes(DATA_W)-1:0]    req_be;
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [DATA_W-1:0]           rsp_rdata;
    logic                        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - DEPTH x DATA_W storage with per-lane write and registered read
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [lanes(DATA_W)-1:0]   be,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       re,
    output logic [DATA_W-1:0]          rdata
);

    localparam int NL = lanes(DATA_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Contents are deliberately not reset; the read register only moves on re
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NL; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - valid/ready data-memory controller with wait states and range check
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic  clk,
    input  logic  rst_n,
    dmem_if.slave bus
);

    localparam int NL = lanes(DATA_W);
    localparam int AW = $clog2(DEPTH);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [NL-1:0]         be_q, be_d;
    logic                  err_q, err_d;
    logic                  rd_sel_q, rd_sel_d;
    logic                  rst_done_q;

    logic                  in_range;
    logic                  access;
    logic                  arr_we;
    logic                  arr_re;
    logic [DATA_W-1:0]     arr_rdata;

    assign in_range = {1'b0, addr_q} < (ADDR_W+1)'(DEPTH);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        err_d    = err_q;
        rd_sel_d = rd_sel_q;
        access   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_done_q && bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    be_d    = bus.req_be;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    access   = 1'b1;
                    err_d    = !in_range;
                    rd_sel_d = in_range && !we_q;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gating with rst_n drops a write whose access edge coincides with reset
    assign arr_we = access && we_q && in_range && rst_n;
    assign arr_re = access && !we_q && in_range && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rd_sel_q   <= 1'b0;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rd_sel_q   <= rd_sel_d;
            rst_done_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .be    (be_q),
        .addr  (addr_q[AW-1:0]),
        .wdata (wdata_q),
        .re    (arr_re),
        .rdata (arr_rdata)
    );

    // rd_sel_q masks the array register so writes, errors and reset read as zero
    assign bus.req_ready = rst_done_q && (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rd_sel_q ? arr_rdata : '0;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - scoreboard bench for dmem_ctrl with WAIT_CYCLES 0 and 3
module tb_dmem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_if #(.DATA_W(16), .ADDR_W(16)) bus0 ();
    dmem_if #(.DATA_W(16), .ADDR_W(16)) bus3 ();

    dmem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    dmem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3));

    logic        req_valid [2];
    logic        req_we    [2];
    logic [15:0] req_addr  [2];
    logic [15:0] req_wdata [2];
    logic [1:0]  req_be    [2];
    logic        rsp_ready [2];
    logic        req_ready_o [2];
    logic        rsp_valid_o [2];
    logic [15:0] rsp_rdata_o [2];
    logic        rsp_err_o   [2];

    assign bus0.req_valid = req_valid[0];
    assign bus0.req_we    = req_we[0];
    assign bus0.req_addr  = req_addr[0];
    assign bus0.req_wdata = req_wdata[0];
    assign bus0.req_be    = req_be[0];
    assign bus0.rsp_ready = rsp_ready[0];
    assign bus3.req_valid = req_valid[1];
    assign bus3.req_we    = req_we[1];
    assign bus3.req_addr  = req_addr[1];
    assign bus3.req_wdata = req_wdata[1];
    assign bus3.req_be    = req_be[1];
    assign bus3.rsp_ready = rsp_ready[1];
    assign req_ready_o[0] = bus0.req_ready;
    assign rsp_valid_o[0] = bus0.rsp_valid;
    assign rsp_rdata_o[0] = bus0.rsp_rdata;
    assign rsp_err_o[0]   = bus0.rsp_err;
    assign req_ready_o[1] = bus3.req_ready;
    assign rsp_valid_o[1] = bus3.rsp_valid;
    assign rsp_rdata_o[1] = bus3.rsp_rdata;
    assign rsp_err_o[1]   = bus3.rsp_err;

    // Reference model: plain word array per instance plus expected {err, rdata}
    logic [15:0] mem_m [2][256];
    logic [16:0] exp0 [$];
    logic [16:0] exp1 [$];
    int          acc_cyc [2];
    logic        was_v   [2];
    logic [16:0] held    [2];
    bit          bp_rand = 1'b0;

    int total  = 0;
    int passed = 0;

    function automatic int wt(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h required %h", name, got, exp);
    endtask

    task automatic push_exp(input int d, input logic [16:0] v);
        if (d == 0) exp0.push_back(v);
        else        exp1.push_back(v);
    endtask

    task automatic do_req(input int d, input bit we, input int addr,
                          input logic [15:0] wdata, input logic [1:0] be, input bit track);
        int n = 0;
        while (req_ready_o[d] !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) begin
            chk("req_ready_timeout", 32'd0, 32'd1);
            return;
        end
        req_we[d]    = we;
        req_addr[d]  = addr[15:0];
        req_wdata[d] = wdata;
        req_be[d]    = be;
        req_valid[d] = 1'b1;
        @(posedge clk); #1;
        acc_cyc[d]   = cyc;
        req_valid[d] = 1'b0;
        req_we[d]    = 1'($urandom_range(0, 1));
        req_addr[d]  = 16'($urandom);
        req_wdata[d] = 16'($urandom);
        req_be[d]    = 2'($urandom_range(0, 3));
        chk("ready_low_busy", 32'(req_ready_o[d]), 32'd0);
        if (track) begin
            if (addr >= 256) begin
                push_exp(d, {1'b1, 16'h0000});
            end else if (we) begin
                for (int i = 0; i < 2; i++)
                    if (be[i]) mem_m[d][addr][8*i +: 8] = wdata[8*i +: 8];
                push_exp(d, {1'b0, 16'h0000});
            end else begin
                push_exp(d, {1'b0, mem_m[d][addr]});
            end
        end
    endtask

    task automatic chk_reset_outputs(input int d);
        chk("rst_req_ready", 32'(req_ready_o[d]), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o[d]), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata_o[d]), 32'd0);
        chk("rst_rsp_err",   32'(rsp_err_o[d]),   32'd0);
    endtask

    task automatic mon(input int d);
        logic [16:0] e;
        logic [16:0] got;
        got = {rsp_err_o[d], rsp_rdata_o[d]};
        if (rsp_valid_o[d] === 1'b1) begin
            if (!was_v[d]) chk("latency", 32'(cyc - acc_cyc[d]), 32'(wt(d) + 1));
            else           chk("rsp_hold", 32'(got), 32'(held[d]));
            chk("ready_vs_valid", 32'(req_ready_o[d]), 32'd0);
            if (rsp_ready[d] === 1'b1) begin
                if ((d == 0 && exp0.size() == 0) || (d == 1 && exp1.size() == 0)) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = (d == 0) ? exp0.pop_front() : exp1.pop_front();
                    chk("rsp_err_rdata", 32'(got), 32'(e));
                end
                was_v[d] = 1'b0;
            end else begin
                was_v[d] = 1'b1;
                held[d]  = got;
            end
        end else begin
            was_v[d] = 1'b0;
        end
    endtask

    initial begin
        was_v = '{1'b0, 1'b0};
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                mon(0);
                mon(1);
            end else begin
                was_v = '{1'b0, 1'b0};
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (bp_rand) rsp_ready[1] = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int n;
        int a;
        rst_n     = 1'b0;
        req_valid = '{1'b0, 1'b0};
        req_we    = '{1'b0, 1'b0};
        req_addr  = '{16'h0, 16'h0};
        req_wdata = '{16'h0, 16'h0};
        req_be    = '{2'b00, 2'b00};
        rsp_ready = '{1'b1, 1'b1};
        acc_cyc   = '{0, 0};
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_release0", 32'(req_ready_o[0]), 32'd1);
        chk("ready_after_release3", 32'(req_ready_o[1]), 32'd1);

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 32; i++)
                do_req(d, 1'b1, i, 16'($urandom), 2'b11, 1'b1);

        do_req(0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, 1'b1);
        do_req(0, 1'b0, 16'h0010, 16'h0000, 2'b00, 1'b1);

        do_req(0, 1'b1, 5, 16'h1234, 2'b11, 1'b1);
        do_req(0, 1'b1, 5, 16'hAB00, 2'b10, 1'b1);
        do_req(0, 1'b0, 5, 16'h0000, 2'b11, 1'b1);
        do_req(0, 1'b1, 5, 16'hFFFF, 2'b00, 1'b1);
        do_req(0, 1'b0, 5, 16'h0000, 2'b11, 1'b1);

        do_req(1, 1'b0, 7, 16'h0000, 2'b11, 1'b1);

        // Backpressure: a write arriving while RESP is held must be ignored
        n = 0;
        while (req_ready_o[0] !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        rsp_ready[0] = 1'b0;
        do_req(0, 1'b0, 16'h0010, 16'h0000, 2'b11, 1'b1);
        n = 0;
        while (rsp_valid_o[0] !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        chk("bp_valid_seen", 32'(rsp_valid_o[0]), 32'd1);
        for (int i = 0; i < 5; i++) begin
            req_valid[0] = 1'b1;
            req_we[0]    = 1'b1;
            req_addr[0]  = 16'h0010;
            req_wdata[0] = 16'hDEAD;
            req_be[0]    = 2'b11;
            @(posedge clk); #1;
            chk("bp_req_ready", 32'(req_ready_o[0]), 32'd0);
            chk("bp_rsp_valid", 32'(rsp_valid_o[0]), 32'd1);
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(rsp_valid_o[0]), 32'd0);
        chk("bp_release_ready", 32'(req_ready_o[0]), 32'd1);
        do_req(0, 1'b0, 16'h0010, 16'h0000, 2'b11, 1'b1);

        do_req(0, 1'b1, 16'h0000, 16'h0F0F, 2'b11, 1'b1);
        do_req(0, 1'b1, 16'h0100, 16'h5555, 2'b11, 1'b1);
        do_req(0, 1'b0, 16'h0100, 16'h0000, 2'b11, 1'b1);
        do_req(0, 1'b0, 16'h0000, 16'h0000, 2'b11, 1'b1);

        // Reset on the second BUSY cycle of a write that must never land
        do_req(1, 1'b1, 9, 16'h0000, 2'b11, 1'b1);
        do_req(1, 1'b1, 9, 16'h7777, 2'b11, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        @(posedge clk); #1;
        chk_reset_outputs(1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_valid", 32'(rsp_valid_o[1]), 32'd0);
        chk("post_rst_ready", 32'(req_ready_o[1]), 32'd1);
        do_req(1, 1'b0, 9, 16'h0000, 2'b11, 1'b1);

        bp_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            int d;
            d = $urandom_range(0, 1);
            a = ($urandom_range(0, 9) < 3) ? $urandom_range(256, 65535) : $urandom_range(0, 31);
            do_req(d, 1'($urandom_range(0, 1)), a, 16'($urandom),
                   2'($urandom_range(0, 3)), 1'b1);
        end
        bp_rand = 1'b0;
        @(posedge clk); #1;
        rsp_ready[1] = 1'b1;

        n = 0;
        while ((exp0.size() != 0 || exp1.size() != 0) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("drain", 32'(exp0.size() + exp1.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised data-memory block for the riscv16 core, replacing the fixed 256×16 combinational-read array. It adds:

- a valid/ready request channel and a valid/ready response channel;
- byte-lane write strobes and a registered read path;
- a configurable wait-state counter to model slower memories;
- out-of-range address error reporting.

It sits between the core's load/store stage and the data storage, and lets the pipeline stall on memory.

## Interface
Parameters:
- DATA_W, 16, data word width in bits; multiple of 8.
- ADDR_W, 16, request address width (word address).
- DEPTH, 256, number of words implemented; DEPTH ≤ 2^ADDR_W.
- WAIT_CYCLES, 0, extra wait states inserted before each access; range 0..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte-lane write enables; bit i covers wdata[8i+7:8i]; ignored on reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  address ≥ DEPTH.

## Operation
- FSM states: IDLE, BUSY, RESP.
  - IDLE: req_ready=1. On req_valid, latch we/addr/wdata/be, load cnt=WAIT_CYCLES, go to BUSY.
  - BUSY: if cnt≠0, decrement cnt. If cnt==0, perform the access, then go to RESP.
  - RESP: rsp_valid=1. On rsp_ready, go to IDLE.
- Access rules:
  - A write updates only the lanes with be=1.
  - A read captures the full word into the rdata register.
  - If the latched addr ≥ DEPTH: no array access, rdata=0, err=1.
- Only the latched request fields are used after acceptance. req_* inputs are don't-care outside IDLE.
- be=0 write: no array change. It still completes with a normal response (err=0).
- rsp_rdata and rsp_err are held stable throughout RESP until the handshake completes.
- Array contents are not reset.
- Reset (rst_n=0 at an edge), in any state: go to IDLE and clear cnt, rsp_rdata and rsp_err. An in-flight write not yet performed (state BUSY) is discarded. No partial writes.
- Reset values of outputs: req_ready=0 while rst_n=0, 1 on the first cycle after reset release. rsp_valid=0, rsp_rdata=0, rsp_err=0.

## Timing
- Accept edge E0 (IDLE, req_valid=1).
- Access edge is E0+WAIT_CYCLES+1.
- rsp_valid is first visible in the cycle after the access edge, so latency is WAIT_CYCLES+1 cycles from acceptance.
- With rsp_ready held at 1, the RESP→IDLE edge is E0+WAIT_CYCLES+2.
- Minimum initiation interval is WAIT_CYCLES+3 cycles. There is no IDLE bypass, and req_ready never rises in the same cycle as rsp_valid.
- Read-after-write to the same address in back-to-back transactions returns the new data.
- No combinational path from any input to any output, except req_ready and rsp_valid, which decode the state register only.

## Structure
- Shared package dmem_pkg holds:
  - the state enum (IDLE, BUSY, RESP);
  - the WAIT_CYCLES counter width constant (4 bits);
  - the helper for lane count, DATA_W/8.
- Sub-module dmem_array:
  - DEPTH×DATA_W storage;
  - synchronous per-lane write enable;
  - synchronous read, with a read-enable input.
- dmem_ctrl holds the FSM, counter, request latch, range check, and rdata/err registers.

## Test plan
- Reset, then WAIT_CYCLES=0.
  - Stimulus: write addr 0x0010, data 0xBEEF, be=2'b11, then read 0x0010.
  - Required: rsp_valid 1 cycle after each accept, rdata=0xBEEF, err=0, req_ready low through BUSY and RESP.
- Byte lanes.
  - Stimulus: write 0x1234 to addr 5 with be=11, then 0xAB00 with be=10, then read addr 5.
  - Required: rdata=0xAB34. A be=00 write of 0xFFFF to addr 5 leaves 0xAB34 and still returns rsp_valid with err=0.
- Wait states, WAIT_CYCLES=3.
  - Stimulus: read addr 7.
  - Required: rsp_valid first high exactly 4 cycles after the accept edge.
- Response backpressure.
  - Stimulus: hold rsp_ready=0 for 5 cycles after rsp_valid.
  - Required: rsp_valid, rdata and err stay stable, req_ready stays 0, and new req_valid is ignored. Release → IDLE next edge.
- Out of range, DEPTH=256.
  - Stimulus: write 0x0100, data 0x5555; then read 0x0100, then read 0x0000.
  - Required: err=1 and rdata=0 for both 0x0100 accesses. Word 0x0000 is unchanged, confirming no aliasing.
- Reset mid-operation, WAIT_CYCLES=3.
  - Stimulus: pre-load addr 9 with 0x0000, then issue a write of 0x7777 to addr 9. Assert rst_n=0 on the second BUSY cycle. After release, read addr 9.
  - Required: rsp_valid=0 on the cycle after reset, the readback returns 0x0000, and all outputs are at reset values during reset.
